// File: rtl/vga_text_pkg.sv
// Shared constants, FSM state type and helpers for the VGA text-mode cell fetch path.
// Build option: TEXT_CURSOR_EN enables the blinking block cursor override.
package vga_text_pkg;

    localparam int unsigned DEF_COLS   = 80;
    localparam int unsigned DEF_ROWS   = 30;
    localparam int unsigned DEF_FONT_H = 16;
    localparam int unsigned DEF_TA_W   = 12;

    localparam int unsigned TXT_DW     = 16;
    localparam int unsigned FONT_AW    = 12;
    localparam int unsigned FONT_DW    = 8;
    localparam int unsigned CELL_W     = 7;
    localparam int unsigned PIX_DELAY  = 5;

    localparam int unsigned CUR_LINE_A = 14;
    localparam int unsigned CUR_LINE_B = 15;
    localparam int unsigned BLINK_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TXT  = 2'd1,
        ST_FONT = 2'd2,
        ST_LOAD = 2'd3
    } fetch_state_t;

    function automatic logic [FONT_AW-1:0] font_index(input logic [7:0] ch, input logic [3:0] line);
        return {ch, line};
    endfunction

endpackage

// File: rtl/text_port_arbiter.sv
// Single text-RAM port shared between the cell fetch (absolute priority) and a host port.
// Generates the one-cycle host acknowledge and gates out-of-range host addresses.
module text_port_arbiter
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned TA_W = DEF_TA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [TA_W-1:0]   fetch_addr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [TA_W-1:0]   host_addr,
    input  logic [TXT_DW-1:0] host_wdata,
    output logic [TA_W-1:0]   txt_addr,
    output logic              txt_en,
    output logic              txt_we,
    output logic [TXT_DW-1:0] txt_wdata,
    input  logic [TXT_DW-1:0] txt_rdata,
    output logic              host_ack,
    output logic [TXT_DW-1:0] host_rdata
);

    localparam int unsigned CELLS = COLS * ROWS;

    logic r_armed;
    logic r_host_ack;
    logic r_host_rd;

    logic w_host_take;
    logic w_host_in_range;
    logic w_host_issue;

    // Host drives the port combinationally in its request cycle so read data
    // lands in the ack cycle; the fetch port cycle is registered, so the host
    // only loses the cycles in which that registered fetch read is on the port.
    assign w_host_take     = r_armed && host_req && !fetch_en;
    assign w_host_in_range = (32'(host_addr) < CELLS);
    assign w_host_issue    = w_host_take && w_host_in_range;

    assign txt_en     = fetch_en || w_host_issue;
    assign txt_we     = w_host_issue && host_we;
    assign txt_addr   = w_host_issue ? host_addr : fetch_addr;
    assign txt_wdata  = w_host_issue ? host_wdata : '0;

    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rd ? txt_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed    <= 1'b0;
            r_host_ack <= 1'b0;
            r_host_rd  <= 1'b0;
        end else begin
            r_armed    <= 1'b1;
            r_host_ack <= w_host_take;
            r_host_rd  <= w_host_issue && !host_we;
        end
    end

endmodule

// File: rtl/text_cell_fetch.sv
// Per-cell char/attr and font-line fetch sequencer for VGA text mode, fixed 5-cycle latency.
// Build option: TEXT_CURSOR_EN adds cursor ports, blink counter and cursor-line override.
module text_cell_fetch
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned FONT_H = DEF_FONT_H,
    parameter int unsigned TA_W   = DEF_TA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    output logic [TA_W-1:0]    txt_addr,
    output logic               txt_en,
    output logic               txt_we,
    output logic [TXT_DW-1:0]  txt_wdata,
    input  logic [TXT_DW-1:0]  txt_rdata,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [FONT_DW-1:0] font_data,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [TA_W-1:0]    host_addr,
    input  logic [TXT_DW-1:0]  host_wdata,
    output logic               host_ack,
    output logic [TXT_DW-1:0]  host_rdata,
    output logic [FONT_DW-1:0] font_line_data,
    output logic [2:0]         char_pix_x,
    output logic [7:0]         bg_fg_index,
    output logic               pix_valid
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    input  logic               frame_tick
`endif
);

    localparam int unsigned LINE_W = $clog2(FONT_H);

    fetch_state_t     r_state;
    logic             r_fetch_en;
    logic [TA_W-1:0]  r_fetch_addr;
    logic [3:0]       r_line;
    logic             r_blank;
    logic [7:0]       r_attr;
    logic             r_load_now;
    logic [3:0]       r_dly [PIX_DELAY];

    logic [CELL_W-1:0] w_cell;
    logic [9:0]        w_row;
    logic [3:0]        w_line;
    logic              w_start;
    logic              w_in_range;
    logic [TA_W-1:0]   w_addr;
    logic              w_cur_force;

    assign w_cell     = pix_x[9:3];
    assign w_row      = pix_y >> LINE_W;
    assign w_line     = 4'(pix_y[LINE_W-1:0]);
    assign w_start    = de && (pix_x[2:0] == 3'd0) && (r_state == ST_IDLE);
    assign w_in_range = (32'(w_cell) < COLS) && (32'(w_row) < ROWS);
    assign w_addr     = TA_W'(w_row) * TA_W'(COLS) + TA_W'(w_cell);

`ifdef TEXT_CURSOR_EN
    logic [BLINK_W-1:0] r_blink;
    logic               r_cur_hit;
    logic               w_cur_hit;

    assign w_cur_hit = (w_cell == cursor_col) && (w_row == 10'(cursor_row)) &&
                       ((w_line == 4'(CUR_LINE_A)) || (w_line == 4'(CUR_LINE_B)));
    assign w_cur_force = r_cur_hit && !r_blink[BLINK_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink   <= '0;
            r_cur_hit <= 1'b0;
        end else begin
            if (frame_tick) begin
                r_blink <= r_blink + BLINK_W'(1);
            end
            if (w_start) begin
                r_cur_hit <= w_cur_hit;
            end
        end
    end
`else
    assign w_cur_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_fetch_en     <= 1'b0;
            r_fetch_addr   <= '0;
            r_line         <= '0;
            r_blank        <= 1'b0;
            r_attr         <= '0;
            r_load_now     <= 1'b0;
            font_addr      <= '0;
            font_line_data <= '0;
            bg_fg_index    <= '0;
        end else begin
            r_fetch_en <= 1'b0;
            r_load_now <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_TXT;
                        r_fetch_en <= w_in_range;
                        r_line     <= w_line;
                        r_blank    <= !w_in_range;
                        if (w_in_range) begin
                            r_fetch_addr <= w_addr;
                        end
                    end
                end
                ST_TXT: begin
                    r_state <= ST_FONT;
                end
                ST_FONT: begin
                    r_state <= ST_LOAD;
                    if (!r_blank) begin
                        font_addr <= font_index(txt_rdata[7:0], r_line);
                        r_attr    <= txt_rdata[15:8];
                    end
                end
                ST_LOAD: begin
                    r_state    <= ST_IDLE;
                    r_load_now <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // ROM data for this cell is valid one cycle after LOAD.
            if (r_load_now) begin
                if (r_blank) begin
                    font_line_data <= '0;
                    bg_fg_index    <= '0;
                end else begin
                    font_line_data <= w_cur_force ? 8'hFF : font_data;
                    bg_fg_index    <= r_attr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIX_DELAY; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= {de, pix_x[2:0]};
            for (int unsigned i = 1; i < PIX_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign pix_valid  = r_dly[PIX_DELAY-1][3];
    assign char_pix_x = r_dly[PIX_DELAY-1][2:0];

    text_port_arbiter #(
        .COLS (COLS),
        .ROWS (ROWS),
        .TA_W (TA_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (r_fetch_en),
        .fetch_addr (r_fetch_addr),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .txt_addr   (txt_addr),
        .txt_en     (txt_en),
        .txt_we     (txt_we),
        .txt_wdata  (txt_wdata),
        .txt_rdata  (txt_rdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata)
    );

endmodule

// File: tb/tb_text_cell_fetch.sv
// Scoreboard bench for text_cell_fetch: directed cells and host accesses against a text RAM / font ROM model.
// Define TEXT_CURSOR_EN for both bench and RTL to exercise the cursor override.
module tb_text_cell_fetch;

    localparam int TA_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             de = 1'b0;
    logic [9:0]       pix_x = '0;
    logic [9:0]       pix_y = '0;
    logic [TA_W-1:0]  txt_addr;
    logic             txt_en;
    logic             txt_we;
    logic [15:0]      txt_wdata;
    logic [15:0]      txt_rdata = '0;
    logic [11:0]      font_addr;
    logic [7:0]       font_data = '0;
    logic             host_req = 1'b0;
    logic             host_we = 1'b0;
    logic [TA_W-1:0]  host_addr = '0;
    logic [15:0]      host_wdata = '0;
    logic             host_ack;
    logic [15:0]      host_rdata;
    logic [7:0]       font_line_data;
    logic [2:0]       char_pix_x;
    logic [7:0]       bg_fg_index;
    logic             pix_valid;
`ifdef TEXT_CURSOR_EN
    logic [6:0]       cursor_col = 7'd2;
    logic [4:0]       cursor_row = 5'd0;
    logic             frame_tick = 1'b0;
`endif

    text_cell_fetch #(
        .COLS   (80),
        .ROWS   (30),
        .FONT_H (16),
        .TA_W   (TA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .de             (de),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .txt_addr       (txt_addr),
        .txt_en         (txt_en),
        .txt_we         (txt_we),
        .txt_wdata      (txt_wdata),
        .txt_rdata      (txt_rdata),
        .font_addr      (font_addr),
        .font_data      (font_data),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rdata     (host_rdata),
        .font_line_data (font_line_data),
        .char_pix_x     (char_pix_x),
        .bg_fg_index    (bg_fg_index),
        .pix_valid      (pix_valid)
`ifdef TEXT_CURSOR_EN
        ,
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .frame_tick     (frame_tick)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [4096];
    logic [7:0]  rom [4096];

    always @(posedge clk) begin
        if (txt_en) begin
            if (txt_we) mem[txt_addr] <= txt_wdata;
            else        txt_rdata     <= mem[txt_addr];
        end
        font_data <= rom[font_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] fld;
        logic [7:0] bg;
        logic [2:0] cpx;
    } pix_exp_t;

    typedef struct {
        int          due;
        bit          chk_data;
        logic [15:0] rd;
    } host_exp_t;

    pix_exp_t  pq[$];
    host_exp_t hq[$];
    pix_exp_t  pe;
    host_exp_t he;

    int n_cmp = 0;
    int n_bad = 0;
    bit count_fetch = 1'b0;
    int n_fetch_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (count_fetch && txt_en && !txt_we) n_fetch_rd++;
        if (pix_valid) begin
            if (pq.size() == 0) begin
                chk("pix_unexpected", 32'(pix_valid), 32'd0);
            end else begin
                pe = pq.pop_front();
                chk("pix_cycle", cyc, pe.due);
                chk("pix_data", {13'd0, font_line_data, bg_fg_index, char_pix_x},
                                {13'd0, pe.fld, pe.bg, pe.cpx});
            end
        end
        if (host_ack) begin
            if (hq.size() == 0) begin
                chk("ack_unexpected", 32'(host_ack), 32'd0);
            end else begin
                he = hq.pop_front();
                chk("ack_cycle", cyc, he.due);
                if (he.chk_data) chk("host_rdata", 32'(host_rdata), 32'(he.rd));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8-pixel cell; checks the fetch address at E1 and font address at E3.
    task automatic drive_cell(input logic [9:0] x0, input logic [9:0] y, input logic [7:0] efld,
                              input logic [7:0] ebg, input bit do_fetch,
                              input logic [TA_W-1:0] eaddr, input logic [11:0] efa);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (do_fetch && i == 1) begin
                chk("txt_en_E1", 32'(txt_en), 32'd1);
                chk("txt_addr_E1", 32'(txt_addr), 32'(eaddr));
            end
            if (!do_fetch && i == 1) chk("suppressed_txt_en", 32'(txt_en), 32'd0);
            if (do_fetch && i == 3) chk("font_addr_E3", 32'(font_addr), 32'(efa));
            de = 1'b1;
            pix_x = x0 + 10'(i);
            pix_y = y;
            pq.push_back('{due: cyc + 5, fld: efld, bg: ebg, cpx: 3'(i)});
        end
        @(posedge clk); #1;
        de = 1'b0;
    endtask

    task automatic host_access(input bit we, input logic [TA_W-1:0] a, input logic [15:0] wd,
                               input bit chkd, input logic [15:0] exp_rd, input int lat);
        bit got;
        host_req = 1'b1;
        host_we = we;
        host_addr = a;
        host_wdata = wd;
        hq.push_back('{due: cyc + lat, chk_data: chkd, rd: exp_rd});
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (host_ack) got = 1'b1;
        end
        host_req = 1'b0;
        host_we = 1'b0;
        chk("host_ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            rom[i] = '0;
        end
        mem[0]    = 16'h1E41;  rom[12'h410] = 8'h18;
        mem[162]  = 16'h2A42;  rom[12'h423] = 8'h5A;
        mem[3]    = 16'h0C43;  rom[12'h430] = 8'h3C;
        mem[4]    = 16'h7744;  rom[12'h440] = 8'h81;
        mem[2]    = 16'h5F47;  rom[12'h47F] = 8'h24;
        mem[2400] = 16'hDEAD;  rom[12'hEF0] = 8'hC3;

        repeat (3) @(negedge clk);
        chk("rst_txt_en", 32'(txt_en), 32'd0);
        chk("rst_txt_we", 32'(txt_we), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_data", {8'd0, font_line_data, bg_fg_index, 5'd0, char_pix_x},  32'd0);
        chk("rst_addr", {8'd0, font_addr, txt_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Cell (0,0) line 0, then cell (2,2) line 3.
        drive_cell(10'd0, 10'd0, 8'h18, 8'h1E, 1'b1, 12'd0, 12'h410);
        idle(8);
        drive_cell(10'd16, 10'd35, 8'h5A, 8'h2A, 1'b1, 12'd162, 12'h423);
        idle(8);

        // Column 80 is off the text grid: blank load, no RAM read.
        drive_cell(10'd640, 10'd0, 8'h00, 8'h00, 1'b0, 12'd0, 12'd0);
        idle(8);

        // Host write collides with the fetch read of cell 3.
        fork
            drive_cell(10'd24, 10'd0, 8'h3C, 8'h0C, 1'b1, 12'd3, 12'h430);
            begin
                repeat (2) @(posedge clk); #1;
                host_access(1'b1, 12'd5, 16'hBEEF, 1'b0, 16'h0, 2);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("contend_txt_we", 32'(txt_we), 32'd0);
                chk("contend_txt_addr", 32'(txt_addr), 32'd3);
            end
        join
        idle(8);
        fork
            host_access(1'b0, 12'd5, 16'h0, 1'b1, 16'hBEEF, 1);
            begin
                @(negedge clk);
                chk("read_txt_en", 32'(txt_en), 32'd1);
            end
        join
        idle(1);

        // de=0: ten back-to-back host writes, one ack every other cycle.
        count_fetch = 1'b1;
        for (int i = 0; i < 10; i++) begin
            host_access(1'b1, 12'(100 + i), 16'h1000 + 16'(i), 1'b0, 16'h0, 1);
            idle(1);
        end
        count_fetch = 1'b0;
        chk("de0_fetch_reads", 32'(n_fetch_rd), 32'd0);
        host_access(1'b0, 12'd100, 16'h0, 1'b1, 16'h1000, 1);
        idle(1);
        host_access(1'b0, 12'd109, 16'h0, 1'b1, 16'h1009, 1);
        idle(1);

        // Out-of-range host read.
        fork
            host_access(1'b0, 12'd2400, 16'h0, 1'b1, 16'h0000, 1);
            begin
                @(negedge clk);
                chk("oor_txt_en", 32'(txt_en), 32'd0);
            end
        join
        idle(4);

        // Reset at E3 of a fetch of cell 4.
        for (int i = 0; i < 3; i++) begin
            de = 1'b1;
            pix_x = 10'd32 + 10'(i);
            pix_y = 10'd0;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        de = 1'b0;
        @(negedge clk);
        chk("midrst_font_addr", 32'(font_addr), 32'd0);
        chk("midrst_data", {16'd0, font_line_data, bg_fg_index}, 32'd0);
        chk("midrst_port", {18'd0, txt_en, txt_we, txt_addr}, 32'd0);
        chk("midrst_pix", {27'd0, host_ack, pix_valid, char_pix_x}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        drive_cell(10'd40, 10'd0, 8'hC3, 8'hBE, 1'b1, 12'd5, 12'hEF0);
        idle(8);

`ifdef TEXT_CURSOR_EN
        drive_cell(10'd16, 10'd15, 8'hFF, 8'h5F, 1'b1, 12'd2, 12'h47F);
        idle(8);
        for (int i = 0; i < 16; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
        end
        idle(2);
        drive_cell(10'd16, 10'd15, 8'h24, 8'h5F, 1'b1, 12'd2, 12'h47F);
        idle(8);
`endif

        idle(10);
        chk("pix_queue_drained", 32'(pq.size()), 32'd0);
        chk("host_queue_drained", 32'(hq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
